// File: rtl/sprite_blitter_if.sv
// Sprite blitter command and pixel-write handshakes.
// master = command host / pixel sink, slave = blitter.
interface sprite_blitter_if #(
    parameter int ADDR_W = 16
);
    logic              cmd_valid;
    logic              cmd_ready;
    logic [9:0]        cmd_x;
    logic [9:0]        cmd_y;
    logic [6:0]        cmd_w;
    logic [6:0]        cmd_h;
    logic [ADDR_W-1:0] cmd_base;

    logic              program_valid;
    logic              program_ready;
    logic [9:0]        program_x;
    logic [9:0]        program_y;
    logic [15:0]       program_data;

    modport master (
        output cmd_valid,
        output cmd_x,
        output cmd_y,
        output cmd_w,
        output cmd_h,
        output cmd_base,
        input  cmd_ready,
        input  program_valid,
        input  program_x,
        input  program_y,
        input  program_data,
        output program_ready
    );

    modport slave (
        input  cmd_valid,
        input  cmd_x,
        input  cmd_y,
        input  cmd_w,
        input  cmd_h,
        input  cmd_base,
        output cmd_ready,
        output program_valid,
        output program_x,
        output program_y,
        output program_data,
        input  program_ready
    );
endinterface

// File: rtl/sprite_blitter.sv
// Walks one sprite through a sync ROM and emits
// clipped, colour-keyed pixel writes row-major.
module sprite_blitter #(
    parameter int          ADDR_W      = 16,
    parameter logic [15:0] TRANSPARENT = 16'hF81F,
    parameter int          SCREEN_W    = 640,
    parameter int          SCREEN_H    = 480
) (
    input  logic              clk,
    input  logic              reset_n,
    sprite_blitter_if.slave   bus,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [15:0]       rom_data,
    output logic              busy
);

    typedef enum logic [1:0] {
        IDLE,
        READ,
        LATCH,
        OUT
    } state_t;

    state_t state_q, state_d;

    logic [9:0]        x_q, y_q;
    logic [6:0]        w_q, h_q;
    logic [6:0]        col_q, row_q;
    logic [ADDR_W-1:0] addr_q;
    logic [9:0]        px_q, py_q;
    logic [15:0]       pd_q;

    logic        accept;
    logic        zero_size;
    logic        last_col;
    logic        last_pix;
    logic [10:0] px, py;
    logic        skip;
    logic        advance;

    assign accept    = (state_q == IDLE) && bus.cmd_valid;
    assign zero_size = (bus.cmd_w == 7'd0) || (bus.cmd_h == 7'd0);
    assign last_col  = (col_q == w_q - 7'd1);
    assign last_pix  = last_col && (row_q == h_q - 7'd1);

    // 11-bit sums so a sprite hanging off the edge never wraps on-screen
    assign px = {1'b0, x_q} + {4'd0, col_q};
    assign py = {1'b0, y_q} + {4'd0, row_q};

    assign skip = (rom_data == TRANSPARENT)
               || (px >= 11'(SCREEN_W))
               || (py >= 11'(SCREEN_H));

    assign advance = ((state_q == LATCH) && skip)
                  || ((state_q == OUT) && bus.program_ready);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (bus.cmd_valid && !zero_size) begin
                    state_d = READ;
                end
            end
            READ: begin
                state_d = LATCH;
            end
            LATCH: begin
                if (!skip) begin
                    state_d = OUT;
                end else if (last_pix) begin
                    state_d = IDLE;
                end else begin
                    state_d = READ;
                end
            end
            OUT: begin
                if (bus.program_ready) begin
                    state_d = last_pix ? IDLE : READ;
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            x_q    <= '0;
            y_q    <= '0;
            w_q    <= '0;
            h_q    <= '0;
            col_q  <= '0;
            row_q  <= '0;
            addr_q <= '0;
            px_q   <= '0;
            py_q   <= '0;
            pd_q   <= '0;
        end else begin
            if (accept) begin
                x_q    <= bus.cmd_x;
                y_q    <= bus.cmd_y;
                w_q    <= bus.cmd_w;
                h_q    <= bus.cmd_h;
                col_q  <= '0;
                row_q  <= '0;
                addr_q <= bus.cmd_base;
            end
            if (advance) begin
                addr_q <= addr_q + ADDR_W'(1);
                if (last_col) begin
                    col_q <= '0;
                    row_q <= row_q + 7'd1;
                end else begin
                    col_q <= col_q + 7'd1;
                end
            end
            if ((state_q == LATCH) && !skip) begin
                px_q <= px[9:0];
                py_q <= py[9:0];
                pd_q <= rom_data;
            end
        end
    end

    assign rom_addr          = addr_q;
    assign busy              = (state_q != IDLE);
    assign bus.cmd_ready     = (state_q == IDLE);
    assign bus.program_valid = (state_q == OUT);
    assign bus.program_x     = px_q;
    assign bus.program_y     = py_q;
    assign bus.program_data  = pd_q;

endmodule

// File: tb/tb_sprite_blitter.sv
// Directed and randomized checks of sprite_blitter
// against a loop-based sprite drawing model.
module tb_sprite_blitter;

    localparam int ADDR_W = 16;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    logic [ADDR_W-1:0] rom_addr;
    logic [15:0]       rom_data;
    logic              busy;
    logic [15:0]       rom_mem [0:65535];

    sprite_blitter_if #(.ADDR_W(ADDR_W)) bus ();

    sprite_blitter #(.ADDR_W(ADDR_W)) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .bus      (bus),
        .rom_addr (rom_addr),
        .rom_data (rom_data),
        .busy     (busy)
    );

    always @(posedge clk) rom_data <= rom_mem[rom_addr];

    typedef struct packed {
        logic [9:0]  x;
        logic [9:0]  y;
        logic [15:0] d;
    } pix_t;

    pix_t        got_q[$];
    pix_t        exp_q[$];
    logic [15:0] addr_q[$];
    int          busy_cyc, stall_cyc, stall_moved;
    pix_t        last_px;
    logic        last_stall = 1'b0;
    int          n_pass = 0;
    int          n_checks = 0;

    logic hold_low = 1'b0;
    logic rand_ready = 1'b0;
    logic arm_stall = 1'b0;
    int   stall_left = 0;

    always @(negedge clk) begin
        pix_t cur;
        cur = '{bus.program_x, bus.program_y, bus.program_data};
        if (!reset_n) begin
            last_stall = 1'b0;
        end else begin
            if (busy) begin
                busy_cyc++;
                if (addr_q.size() == 0 || addr_q[$] != rom_addr)
                    addr_q.push_back(rom_addr);
            end
            if (bus.program_valid) begin
                if (last_stall && cur != last_px) stall_moved++;
                if (bus.program_ready) begin
                    got_q.push_back(cur);
                    last_stall = 1'b0;
                end else begin
                    stall_cyc++;
                    last_stall = 1'b1;
                end
                last_px = cur;
            end else begin
                last_stall = 1'b0;
            end
        end
    end

    initial begin
        bus.program_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            if (arm_stall && bus.program_valid) begin
                arm_stall  = 1'b0;
                stall_left = 5;
            end
            if (hold_low) begin
                bus.program_ready = 1'b0;
            end else if (stall_left > 0) begin
                bus.program_ready = 1'b0;
                stall_left--;
            end else if (rand_ready) begin
                bus.program_ready = ($urandom_range(0, 2) != 0);
            end else begin
                bus.program_ready = 1'b1;
            end
        end
    end

    initial begin
        #3000000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        n_checks++;
        assert (got === exp) n_pass++;
        else $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    endtask

    // Expected writes and cycle cost from the drawing rules alone.
    task automatic model(input int x, input int y, input int w,
                         input int h, input int b, output int cost);
        exp_q.delete();
        cost = 0;
        for (int r = 0; r < h; r++) begin
            for (int c = 0; c < w; c++) begin
                int          px, py;
                logic [15:0] d;
                d  = rom_mem[(b + r * w + c) & 16'hFFFF];
                px = x + c;
                py = y + r;
                if (d == 16'hF81F || px >= 640 || py >= 480) begin
                    cost += 2;
                end else begin
                    exp_q.push_back('{10'(px), 10'(py), d});
                    cost += 3;
                end
            end
        end
    endtask

    task automatic send(input int x, input int y, input int w,
                        input int h, input int b, output int waited);
        bus.cmd_x     = 10'(x);
        bus.cmd_y     = 10'(y);
        bus.cmd_w     = 7'(w);
        bus.cmd_h     = 7'(h);
        bus.cmd_base  = 16'(b);
        bus.cmd_valid = 1'b1;
        waited = 0;
        @(negedge clk);
        while (!bus.cmd_ready && waited < 2000) begin
            waited++;
            @(negedge clk);
        end
        @(posedge clk);
        #1;
        bus.cmd_valid = 1'b0;
    endtask

    task automatic run(input string tag, input int x, input int y,
                       input int w, input int h, input int b);
        int cost, waited, n, bad;
        got_q.delete();
        addr_q.delete();
        busy_cyc    = 0;
        stall_cyc   = 0;
        stall_moved = 0;
        model(x, y, w, h, b, cost);
        send(x, y, w, h, b, waited);
        check({tag, "_accept"}, 64'(waited < 2000), 64'd1);
        if (w > 0 && h > 0) check({tag, "_latency"}, 64'(busy), 64'd1);
        n = 0;
        while ((busy || !bus.cmd_ready) && n < 5000) begin
            @(negedge clk);
            n++;
        end
        @(posedge clk);
        #1;
        check({tag, "_done"}, 64'(n < 5000), 64'd1);
        check({tag, "_count"}, 64'(got_q.size()), 64'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
            check({tag, "_pix"}, 64'(got_q[i]), 64'(exp_q[i]));
        check({tag, "_busy"}, 64'(busy_cyc), 64'(cost + stall_cyc));
        bad = (addr_q.size() == w * h) ? 0 : 1;
        for (int i = 0; i < addr_q.size(); i++)
            if (addr_q[i] != 16'((b + i) & 16'hFFFF)) bad++;
        check({tag, "_addr"}, 64'(bad), 64'd0);
    endtask

    initial begin
        int waited, n;
        bus.cmd_valid = 1'b0;
        bus.cmd_x = '0;
        bus.cmd_y = '0;
        bus.cmd_w = '0;
        bus.cmd_h = '0;
        bus.cmd_base = '0;
        for (int i = 0; i < 65536; i++) rom_mem[i] = 16'(i ^ 16'h5A5A);

        repeat (3) @(posedge clk);
        #1;
        check("rst_ready", 64'(bus.cmd_ready), 64'd1);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_valid", 64'(bus.program_valid), 64'd0);
        check("rst_out", 64'({bus.program_x, bus.program_y,
                              bus.program_data}), 64'd0);
        check("rst_addr", 64'(rom_addr), 64'd0);
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk);
        #1;

        for (int i = 0; i < 4; i++) rom_mem[16'h100 + i] = 16'(i + 1);
        run("t1", 100, 200, 2, 2, 16'h100);
        check("t1_busy12", 64'(busy_cyc), 64'd12);

        rom_mem[16'h200] = 16'd1;
        rom_mem[16'h201] = 16'hF81F;
        rom_mem[16'h202] = 16'd3;
        rom_mem[16'h203] = 16'd4;
        run("t2", 100, 200, 2, 2, 16'h200);
        check("t2_busy11", 64'(busy_cyc), 64'd11);

        for (int i = 0; i < 4; i++) rom_mem[16'h300 + i] = 16'(16'h0A0 + i);
        run("t3", 639, 479, 2, 2, 16'h300);
        check("t3_busy9", 64'(busy_cyc), 64'd9);

        arm_stall = 1'b1;
        run("t4", 100, 200, 2, 2, 16'h100);
        check("t4_busy17", 64'(busy_cyc), 64'd17);
        check("t4_stall", 64'(stall_cyc), 64'd5);
        check("t4_stable", 64'(stall_moved), 64'd0);

        send(0, 0, 0, 3, 16'h100, waited);
        check("t5_ready", 64'(bus.cmd_ready), 64'd1);
        check("t5_busy", 64'(busy), 64'd0);
        check("t5_valid", 64'(bus.program_valid), 64'd0);
        run("t5", 100, 200, 2, 2, 16'h100);

        hold_low = 1'b1;
        send(100, 200, 2, 2, 16'h100, waited);
        n = 0;
        while (!bus.program_valid && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("t6_reached_out", 64'(bus.program_valid), 64'd1);
        @(negedge clk);
        reset_n = 1'b0;
        #1;
        check("t6_valid", 64'(bus.program_valid), 64'd0);
        check("t6_busy", 64'(busy), 64'd0);
        check("t6_ready", 64'(bus.cmd_ready), 64'd1);
        check("t6_out", 64'({bus.program_x, bus.program_y,
                             bus.program_data}), 64'd0);
        check("t6_addr", 64'(rom_addr), 64'd0);
        hold_low = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk);
        #1;
        run("t6", 100, 200, 2, 2, 16'h100);
        check("t6_busy12", 64'(busy_cyc), 64'd12);

        rand_ready = 1'b1;
        run("wrap", 630, 10, 3, 2, 16'hFFFE);
        for (int k = 0; k < 12; k++) begin
            int x, y, w, h, b;
            x = ($urandom_range(0, 1) != 0) ? $urandom_range(600, 639)
                                            : $urandom_range(0, 639);
            y = ($urandom_range(0, 1) != 0) ? $urandom_range(440, 479)
                                            : $urandom_range(0, 479);
            w = $urandom_range(0, 8);
            h = $urandom_range(0, 8);
            b = $urandom_range(0, 65535);
            for (int i = 0; i < w * h; i++)
                rom_mem[(b + i) & 16'hFFFF] =
                    ($urandom_range(0, 3) == 0) ? 16'hF81F
                                                : 16'($urandom);
            run("rnd", x, y, w, h, b);
        end
        rand_ready = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/sprite_blitter.md
# sprite_blitter

Upstream pixel source for `sram_controller`: takes one rectangular sprite draw command, walks the sprite row-major through a synchronous sprite ROM, drops transparent and off-screen pixels, and presents each remaining pixel as a `program_x`/`program_y`/`program_data` write request to the SRAM controller. Replaces the fixed test coordinates and data used while bringing up the controller. Handles one command at a time with a valid/ready handshake on both sides.

## Interface

- `ADDR_W`, 16: sprite ROM address width.
- `TRANSPARENT`, 16'hF81F: colour key; pixels equal to it are not written.
- `SCREEN_W`, 640: horizontal clip limit, exclusive.
- `SCREEN_H`, 480: vertical clip limit, exclusive.

Ports:

- `clk` in 1: system clock. One clock domain.
- `reset_n` in 1: reset, asynchronous, active-low.
- `cmd_valid` in 1: draw command present.
- `cmd_ready` out 1: blitter idle and able to accept a command.
- `cmd_x`, `cmd_y` in 10: screen position of the sprite's top-left pixel.
- `cmd_w`, `cmd_h` in 7: sprite width and height, 0..64.
- `cmd_base` in ADDR_W: ROM address of the sprite's top-left pixel.
- `rom_addr` out ADDR_W: sprite ROM address.
- `rom_data` in 16: ROM read data, valid one cycle after `rom_addr`.
- `program_valid` out 1: write request present.
- `program_ready` in 1: SRAM controller accepts the request.
- `program_x`, `program_y` out 10: write coordinates.
- `program_data` out 16: pixel colour.
- `busy` out 1: a command is in progress (state ≠ IDLE).

## Operation

FSM states are IDLE, READ, LATCH and OUT.

**IDLE**
- `cmd_ready`=1.
- On `cmd_valid & cmd_ready`, latch `cmd_x`, `cmd_y`, `cmd_w`, `cmd_h` and `cmd_base`.
- Clear `col` and `row`, load the address counter with `cmd_base`.
- Go to READ, unless `cmd_w`==0 or `cmd_h`==0. In that case the command is consumed and the state stays IDLE with no output.

**READ**
- Drive `rom_addr` = address counter, then go to LATCH.

**LATCH**
- Register `rom_data`.
- Compute `px` = `x` + `col` and `py` = `y` + `row` at 11 bits, no wrap.
- If `rom_data`==TRANSPARENT, or `px`≥SCREEN_W, or `py`≥SCREEN_H, advance.
- Otherwise load `program_x`=`px`[9:0], `program_y`=`py`[9:0], `program_data`=`rom_data`, and go to OUT.

**OUT**
- `program_valid`=1.
- `program_x`, `program_y` and `program_data` are held stable until `program_ready`=1.
- On that handshake edge, advance.

**Advance**
- The address counter increments by 1 (wraps mod 2^ADDR_W) for every pixel, including skipped ones.
- If `col`==`w`−1, then `col`=0 and `row`++; otherwise `col`++.
- If the pixel was the last one (`col`==`w`−1 and `row`==`h`−1), go to IDLE; otherwise go to READ.

**Invariants**
- Each non-skipped pixel produces exactly one accepted request, in row-major order.
- No request is duplicated or dropped under backpressure.
- `cmd_*` inputs are ignored outside IDLE.

## Timing

- **Reset values:** state IDLE, `cmd_ready`=1, `busy`=0, `program_valid`=0, `program_x`/`program_y`/`program_data`=0, `rom_addr`=0.
- **Reset mid-command:** `reset_n` low aborts the command. Outputs take their reset values asynchronously and the command is discarded.
- **Command latency:** READ is entered on the clock edge that accepts the command.
- **Emitted pixel cost:** 3 cycles (READ, LATCH, OUT) with `program_ready` held high.
- **Skipped pixel cost:** 2 cycles (READ, LATCH).
- **Stall:** each cycle of `program_ready`=0 in OUT adds one cycle.
- **Command cost:** a w×h command takes Σ(per-pixel cost) cycles out of IDLE. `cmd_ready` returns the cycle after the final advance.
- **Output sourcing:** all outputs are registered or decoded from state only. No combinational path from `program_ready` or `cmd_valid` to any output.

## Test plan

1. **Basic 2×2:** `cmd_x`=100, `cmd_y`=200, 2×2 sprite, ROM = 1,2,3,4, `program_ready`=1 → requests (100,200,1), (101,200,2), (100,201,3), (101,201,4). `busy` high for exactly 12 cycles.
2. **Transparent pixel:** same as 1 with ROM[1]=16'hF81F → three requests, no (101,200). `busy` high 11 cycles; `rom_addr` still walks base..base+3.
3. **Clipping:** `cmd_x`=639, `cmd_y`=479, 2×2 sprite, all opaque → only (639,479) written.
4. **Backpressure:** as 1 with `program_ready` low for 5 cycles during the first OUT → `program_valid` and data held stable for 5 cycles. Four requests total, no duplicates; `busy` lasts 17 cycles.
5. **Zero size:** `cmd_w`=0 → command accepted, `busy` never asserts, no `program_valid`. A following valid command is accepted the next cycle.
6. **Reset mid-command:** assert `reset_n`=0 while in OUT → `program_valid`=0 and `busy`=0 immediately. After release, `cmd_ready`=1 and a new command runs as in test 1.
